adc_frame_packer: RTL
=====================

# adc_frame_packer

Parametrised successor to the fixed two-channel sample/counter output register. On each sample tick it snapshots all ADC (or filtered) channels and stamps each word with a channel index and a sequence number. It serialises the words into a first-word-fall-through FIFO that the host readout drains one word per `rd_en_i`. It sits between the input filters and the host-facing output register, and adds frame-atomic overflow detection and a single-channel mode.

## Interface
- `NUM_CH`, 2: channel count, 1..16.
- `DATA_W`, 24: sample width, signed.
- `CNT_W`, 8: stamp field width; top `CH_IDX_W = max(1, $clog2(NUM_CH))` bits hold the channel index, the rest hold `SEQ_W = CNT_W - CH_IDX_W` sequence bits.
- `FIFO_DEPTH`, 16: FIFO depth in words; power of 2, and at least `NUM_CH`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `tick_i` in 1: one-cycle strobe; new samples are valid on `data_i`.
- `data_i` in `NUM_CH*DATA_W`: channel k is at bits `[k*DATA_W +: DATA_W]`.
- `mode_i` in 1: 0 = ALL (emit every channel), 1 = SINGLE (emit `ch_sel_i` only); sampled on tick.
- `ch_sel_i` in `CH_IDX_W`: channel for SINGLE mode; sampled on tick. Values ≥ `NUM_CH` select channel 0.
- `rd_en_i` in 1: pop the head word; ignored when `valid_o` = 0.
- `clear_ovf_i` in 1: clears `overflow_o`.
- `word_o` out `CNT_W+DATA_W`: head word, laid out as `{ch_idx, seq, data}`. Value is 0 when empty.
- `valid_o` out 1: FIFO not empty.
- `level_o` out `$clog2(FIFO_DEPTH)+1`: FIFO occupancy.
- `overflow_o` out 1: sticky; at least one frame was dropped.
- `busy_o` out 1: FSM is in EMIT.

## Operation
- FSM states are IDLE and EMIT.
  - IDLE to EMIT: `tick_i` is high and the frame is accepted.
  - EMIT to IDLE: after the last word of the frame is written.
- On every `tick_i`, regardless of whether the frame is accepted, the stamp `seq` equals the current sequence counter. The counter then increments and wraps at 2^`SEQ_W`.
- Frame length N is `NUM_CH` in ALL mode and 1 in SINGLE mode.
- Acceptance check at the tick edge: the FSM must be in IDLE and `FIFO_DEPTH - level_o ≥ N` must hold. A read in the same cycle is not counted toward free space.
- Accepted frame:
  - All channels, mode and channel select are latched into snapshot registers.
  - In EMIT, one word is written per cycle in ascending channel order; SINGLE mode writes one word.
  - Input changes during EMIT have no effect.
- Dropped frame: no words are written, `overflow_o` is set, and the sequence counter still advances. A tick during EMIT is always dropped, and the frame in progress completes intact.
- Frames are never partial in the FIFO.
- `clear_ovf_i` and a new drop in the same cycle: the set wins.
- FIFO is synchronous first-word-fall-through.
  - A simultaneous write and read keeps `level_o` unchanged.
  - Writes never see a full FIFO, because space is reserved at the tick.
- Data are passed through unmodified: no sign extension, no truncation.

## Timing
- Tick sampled at edge E0 (accepted): word k is written at edge E0+1+k.
- With an empty FIFO, `valid_o` and `word_o` show word 0 in the cycle after E0+1. Latency is 1 cycle from the tick edge to visibility.
- `busy_o` is high from E0 through E0+N, i.e. N cycles.
- Minimum tick spacing for no drops is N+1 cycles.
- `rd_en_i` pops at the edge; the next head is visible in the following cycle.
- Reset values: `word_o` = 0, `valid_o` = 0, `level_o` = 0, `overflow_o` = 0, `busy_o` = 0; FSM in IDLE; sequence counter 0; FIFO emptied.
- Reset mid-EMIT aborts the frame. Words already written are discarded with the FIFO.

## Structure
- Package `adc_packer_pkg`: `state_t` enum {IDLE, EMIT}, `mode_t` enum {MODE_ALL, MODE_SINGLE}, and a function computing `CH_IDX_W`/`SEQ_W`.
- Sub-module `sync_fifo_fwft`, parameterised on WIDTH and DEPTH, with ports `level`, `empty`, `full`.
- Top-level instance replaces the `{counter, data}` concatenation with `word_o` driving the 32-bit output register. Defaults give 32 bits.

## Test plan
- Reset, then ALL tick with ch0 = 24'h123456, ch1 = 24'hFEDCBA:
  - `word_o` = 32'h00123456, then after a pop 32'h80FEDCBA.
  - `level_o` goes 1 → 2 with no reads; `busy_o` is high for 2 cycles.
- Second tick in SINGLE mode with `ch_sel_i` = 1 and ch1 = 24'h000001: single word 32'h81000001.
- 130 ALL ticks with the FIFO drained continuously: the seq field goes 0..127, then 0, 1; `overflow_o` stays 0.
- `FIFO_DEPTH` = 8, no reads, 5 ALL ticks:
  - `level_o` = 8 and `overflow_o` = 1.
  - After draining 2 words, the next tick is accepted and stamped seq = 5.
  - `clear_ovf_i` then clears the flag.
- `NUM_CH` = 4, tick repeated 2 cycles after an accepted tick: the second frame is dropped and `overflow_o` = 1. Exactly 4 words arrive, with indices 0..3 and the same seq.
- Reset asserted during the 2nd EMIT cycle: the next cycle shows `level_o` = 0, `valid_o` = 0, `busy_o` = 0; the following tick is stamped seq = 0.

Source files
------------

// File: rtl/adc_packer_pkg.sv
// Shared types and stamp-field width helpers for the ADC frame packer.
package adc_packer_pkg;

  typedef enum logic {IDLE, EMIT} state_t;
  typedef enum logic {MODE_ALL, MODE_SINGLE} mode_t;

  // Channel index needs at least one bit even with a single channel.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int seq_w(input int num_ch, input int cnt_w);
    return cnt_w - ch_idx_w(num_ch);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head word is combinational, 0 when empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Snapshots all channels on a tick and serialises stamped words {ch_idx, seq, data}
// into a FWFT FIFO; frames are admitted whole or dropped with a sticky overflow flag.
module adc_frame_packer
  import adc_packer_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 24,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int CH_IDX_W  = ch_idx_w(NUM_CH),
  localparam int SEQ_W     = seq_w(NUM_CH, CNT_W),
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1,
  localparam int WORD_W    = CNT_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic                     mode_i,
  input  logic [CH_IDX_W-1:0]      ch_sel_i,
  input  logic                     rd_en_i,
  input  logic                     clear_ovf_i,
  output logic [WORD_W-1:0]        word_o,
  output logic                     valid_o,
  output logic [LVL_W-1:0]         level_o,
  output logic                     overflow_o,
  output logic                     busy_o
);

  state_t                         state_q, state_d;
  mode_t                          mode_q;
  logic [NUM_CH-1:0][DATA_W-1:0]  data_q;
  logic [SEQ_W-1:0]               seq_cnt, seq_q;
  logic [CH_IDX_W-1:0]            sel_q, emit_idx, cur_ch;
  logic [LVL_W-1:0]               need;
  logic [WORD_W-1:0]              wr_word;
  logic                           accept, drop, wr_en, last_word;
  logic                           fifo_empty, fifo_full;

  assign busy_o  = (state_q == EMIT);
  assign valid_o = !fifo_empty;
  assign cur_ch  = (mode_q == MODE_SINGLE) ? sel_q : emit_idx;
  assign wr_word = {cur_ch, seq_q, data_q[cur_ch]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Space for the whole frame is reserved at the tick, so EMIT never stalls.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    drop      = 1'b0;
    wr_en     = 1'b0;
    need      = mode_i ? LVL_W'(1) : LVL_W'(NUM_CH);
    last_word = (mode_q == MODE_SINGLE) || (emit_idx == CH_IDX_W'(NUM_CH - 1));
    case (state_q)
      IDLE: begin
        if (tick_i) begin
          if (LVL_W'(FIFO_DEPTH) - level_o >= need) begin
            accept  = 1'b1;
            state_d = EMIT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      EMIT: begin
        wr_en = 1'b1;
        drop  = tick_i;
        if (last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_cnt    <= '0;
      seq_q      <= '0;
      data_q     <= '0;
      mode_q     <= MODE_ALL;
      sel_q      <= '0;
      emit_idx   <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (tick_i) seq_cnt <= seq_cnt + 1'b1;
      if (accept) begin
        data_q   <= data_i;
        mode_q   <= mode_t'(mode_i);
        sel_q    <= (32'(ch_sel_i) < NUM_CH) ? ch_sel_i : '0;
        seq_q    <= seq_cnt;
        emit_idx <= '0;
      end else if (wr_en) begin
        emit_idx <= emit_idx + 1'b1;
      end
      if (drop)             overflow_o <= 1'b1;
      else if (clear_ovf_i) overflow_o <= 1'b0;
    end
  end

  sync_fifo_fwft #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && !fifo_full),
    .wr_data (wr_word),
    .rd_en   (rd_en_i),
    .rd_data (word_o),
    .level   (level_o),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule
